// File: rtl/tick_pkg.sv
// Shared definitions for the tick scheduler. The package holds the channel
// state encoding, the cfg_mode values and the default prescale ratios.
package tick_pkg;

  // Channel states. The encodings are fixed so that they match other users
  // of this timebase.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ONESHOT  = 2'd1,
    PERIODIC = 2'd2
  } chan_state_t;

  // Values of cfg_mode.
  localparam logic CFG_MODE_ONESHOT  = 1'b0;
  localparam logic CFG_MODE_PERIODIC = 1'b1;

  // PRESCALE_HW is the real divide ratio. PRESCALE_SIM keeps simulations short.
  localparam int PRESCALE_HW  = 1000;
  localparam int PRESCALE_SIM = 10;

endpackage

// File: rtl/tick_chan.sv
// One countdown channel: it holds the FSM state, the remaining count and the
// reload value.
// Loads arrive only when strobe is low, because the top gates the handshake
// with !strobe. A load and a countdown step therefore never share an edge.
module tick_chan
  import tick_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          strobe,
  input  logic          load,
  input  logic [CW-1:0] cfg_period,
  input  logic          cfg_mode,
  input  logic          cfg_stop,
  output logic          expire,
  output logic          active
);

  chan_state_t   state;
  logic [CW-1:0] rem;
  logic [CW-1:0] reload;

  // Channel FSM: a load, a stop or a zero period reprograms the channel;
  // otherwise each tick counts it down.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rem    <= '0;
      reload <= '0;
      expire <= 1'b0;
      active <= 1'b0;
    end else begin
      expire <= 1'b0;
      if (load) begin
        if (cfg_stop || (cfg_period == '0)) begin
          state  <= IDLE;
          rem    <= '0;
          active <= 1'b0;
        end else begin
          rem    <= cfg_period;
          reload <= cfg_period;
          state  <= (cfg_mode == CFG_MODE_PERIODIC) ? PERIODIC : ONESHOT;
          active <= 1'b1;
        end
      end else if (strobe && (state != IDLE)) begin
        if (rem == CW'(1)) begin
          expire <= 1'b1;
          if (state == PERIODIC) begin
            rem <= reload;
          end else begin
            state  <= IDLE;
            rem    <= '0;
            active <= 1'b0;
          end
        end else begin
          rem <= rem - CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/tick_sched.sv
// Shared timebase scheduler.
// A single prescaler produces a one-cycle tick every PRESCALE cycles. CH
// countdown channels share that tick and are programmed through a
// valid/ready port. The tick always wins over a config request, which then
// waits one cycle.
module tick_sched
  import tick_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_HW,
  parameter int CH       = 4,
  parameter int CW       = 16,
  parameter int CHW      = 2
) (
  input  logic           clk_in,
  input  logic           rst,
  input  logic           en,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_period,
  input  logic           cfg_mode,
  input  logic           cfg_stop,
  output logic           tick_out,
  output logic [CH-1:0]  expire,
  output logic [CH-1:0]  active
);

  localparam int PW = $clog2(PRESCALE);

  logic [PW-1:0] pcnt;
  logic          strobe;
  logic          xfer;
  logic [CH-1:0] load;

  assign strobe    = en && (pcnt == PW'(PRESCALE - 1));
  assign cfg_ready = !strobe;
  assign xfer      = cfg_valid && cfg_ready;

  // Prescaler counter and the registered tick. The counter holds while en is low.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      pcnt     <= '0;
      tick_out <= 1'b0;
    end else begin
      tick_out <= strobe;
      if (en) begin
        pcnt <= strobe ? '0 : pcnt + PW'(1);
      end
    end
  end

  // One countdown channel per index. Each channel receives only the
  // transfers addressed to it.
  for (genvar i = 0; i < CH; i++) begin : g_chan
    assign load[i] = xfer && (cfg_ch == CHW'(i));

    tick_chan #(
      .CW(CW)
    ) u_chan (
      .clk_in    (clk_in),
      .rst       (rst),
      .strobe    (strobe),
      .load      (load[i]),
      .cfg_period(cfg_period),
      .cfg_mode  (cfg_mode),
      .cfg_stop  (cfg_stop),
      .expire    (expire[i]),
      .active    (active[i])
    );
  end

endmodule

// File: tb/tb_tick_sched.sv
// Self-checking bench for tick_sched with PRESCALE=10, CH=4 and CW=16.
// cyc counts rising edges since reset release. Outputs are sampled 1ns after each edge.
module tb_tick_sched;

  logic        clk_in;
  logic        rst;
  logic        en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_period;
  logic        cfg_mode;
  logic        cfg_stop;
  logic        tick_out;
  logic [3:0]  expire;
  logic [3:0]  active;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          cyc;
    logic        valid;
    logic [1:0]  ch;
    logic [15:0] period;
    logic        mode;
    logic        stop;
    logic        tick;
    logic [3:0]  expire;
    logic [3:0]  active;
    logic        ready;
  } vec_t;

  vec_t vecs[$];

  tick_sched #(
    .PRESCALE(10),
    .CH      (4),
    .CW      (16),
    .CHW     (2)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_period(cfg_period),
    .cfg_mode  (cfg_mode),
    .cfg_stop  (cfg_stop),
    .tick_out  (tick_out),
    .expire    (expire),
    .active    (active)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic checkOutput(input string tag, input logic t, input logic [3:0] e,
                             input logic [3:0] a, input logic r);
    checkVal({tag, "_tick"}, 16'(tick_out), 16'(t));
    checkVal({tag, "_expire"}, 16'(expire), 16'(e));
    checkVal({tag, "_active"}, 16'(active), 16'(a));
    checkVal({tag, "_ready"}, 16'(cfg_ready), 16'(r));
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] ch, input logic [15:0] p,
                               input logic m, input logic s);
    cfg_valid  = v;
    cfg_ch     = ch;
    cfg_period = p;
    cfg_mode   = m;
    cfg_stop   = s;
  endtask

  task automatic stepCycle();
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  task automatic stepTo(input int n);
    while (cyc < n) stepCycle();
  endtask

  task automatic addVec(input int c, input logic v, input logic [1:0] ch, input logic [15:0] p,
                        input logic m, input logic t, input logic [3:0] e,
                        input logic [3:0] a, input logic r);
    vec_t x;
    x.cyc = c; x.valid = v; x.ch = ch; x.period = p; x.mode = m; x.stop = 1'b0;
    x.tick = t; x.expire = e; x.active = a; x.ready = r;
    vecs.push_back(x);
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 1'b0);

    // Each row: at cycle cyc, check the outputs, then drive the cfg inputs for one edge.
    addVec(0,   1, 0, 3, 0, 0, 4'b0000, 4'b0000, 1);
    addVec(1,   1, 1, 2, 1, 0, 4'b0000, 4'b0001, 1);
    addVec(2,   0, 0, 0, 0, 0, 4'b0000, 4'b0011, 1);
    addVec(9,   0, 0, 0, 0, 0, 4'b0000, 4'b0011, 0);
    addVec(10,  0, 0, 0, 0, 1, 4'b0000, 4'b0011, 1);
    addVec(11,  0, 0, 0, 0, 0, 4'b0000, 4'b0011, 1);
    addVec(20,  0, 0, 0, 0, 1, 4'b0010, 4'b0011, 1);
    addVec(21,  0, 0, 0, 0, 0, 4'b0000, 4'b0011, 1);
    addVec(30,  0, 0, 0, 0, 1, 4'b0001, 4'b0010, 1);
    addVec(31,  0, 0, 0, 0, 0, 4'b0000, 4'b0010, 1);
    addVec(40,  0, 0, 0, 0, 1, 4'b0010, 4'b0010, 1);
    addVec(50,  0, 0, 0, 0, 1, 4'b0000, 4'b0010, 1);
    addVec(60,  1, 1, 5, 1, 1, 4'b0010, 4'b0010, 1);
    addVec(61,  0, 0, 0, 0, 0, 4'b0000, 4'b0010, 1);
    addVec(70,  0, 0, 0, 0, 1, 4'b0000, 4'b0010, 1);
    addVec(80,  0, 0, 0, 0, 1, 4'b0000, 4'b0010, 1);
    addVec(100, 0, 0, 0, 0, 1, 4'b0000, 4'b0010, 1);
    addVec(109, 0, 0, 0, 0, 0, 4'b0000, 4'b0010, 0);
    addVec(110, 0, 0, 0, 0, 1, 4'b0010, 4'b0010, 1);

    // Reset state, checked while rst is still high.
    stepCycle();
    stepCycle();
    checkOutput("reset", 1'b0, 4'b0000, 4'b0000, 1'b1);
    rst = 1'b0;
    cyc = 0;

    foreach (vecs[i]) begin
      stepTo(vecs[i].cyc);
      checkOutput($sformatf("row%0d", i), vecs[i].tick, vecs[i].expire, vecs[i].active, vecs[i].ready);
      applyStimulus(vecs[i].valid, vecs[i].ch, vecs[i].period, vecs[i].mode, 1'b0);
      stepCycle();
      applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 1'b0);
    end

    // Collision: request raised while pcnt==9, so the transfer lands one cycle later.
    stepTo(119);
    applyStimulus(1'b1, 2'd2, 16'd2, 1'b0, 1'b0);
    checkVal("coll_ready_low", 16'(cfg_ready), 16'd0);
    stepCycle();
    checkOutput("coll_tick", 1'b1, 4'b0000, 4'b0010, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 1'b0);
    checkVal("coll_loaded", 16'(active), 16'b0110);
    stepTo(130);
    checkOutput("coll_not_decr", 1'b1, 4'b0000, 4'b0110, 1'b1);
    stepTo(140);
    checkOutput("coll_expire", 1'b1, 4'b0100, 4'b0010, 1'b1);

    // Stop a running channel, then load a zero period.
    stepTo(141);
    applyStimulus(1'b1, 2'd2, 16'd3, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 1'b0);
    checkVal("ch2_run", 16'(active), 16'b0110);
    stepTo(145);
    applyStimulus(1'b1, 2'd2, 16'd7, 1'b1, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 1'b0);
    checkVal("stop_active", 16'(active), 16'b0010);
    stepTo(160);
    checkOutput("stop_t160", 1'b1, 4'b0010, 4'b0010, 1'b1);
    stepTo(161);
    applyStimulus(1'b1, 2'd3, 16'd0, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 1'b0);
    checkVal("zero_period", 16'(active), 16'b0010);
    stepTo(170);
    checkOutput("stop_no_exp", 1'b1, 4'b0000, 4'b0010, 1'b1);

    // Freeze with en low for 25 edges. A config load is still accepted while frozen.
    stepTo(171);
    en = 1'b0;
    stepTo(180);
    checkOutput("frz_t180", 1'b0, 4'b0000, 4'b0010, 1'b1);
    applyStimulus(1'b1, 2'd0, 16'd1, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 1'b0);
    checkVal("frz_cfg", 16'(active), 16'b0011);
    stepTo(196);
    checkVal("frz_tick", 16'(tick_out), 16'd0);
    en = 1'b1;
    stepTo(204);
    checkVal("resume_early", 16'(tick_out), 16'd0);
    stepTo(205);
    checkOutput("resume_t205", 1'b1, 4'b0001, 4'b0010, 1'b1);
    stepTo(225);
    checkOutput("resume_t225", 1'b1, 4'b0000, 4'b0010, 1'b1);
    stepTo(235);
    checkOutput("resume_t235", 1'b1, 4'b0010, 4'b0010, 1'b1);

    // Asynchronous reset applied between edges while ch0 is running periodic.
    stepTo(236);
    applyStimulus(1'b1, 2'd0, 16'd1, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 1'b0);
    stepTo(245);
    checkOutput("pre_rst", 1'b1, 4'b0001, 4'b0011, 1'b1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst", 1'b0, 4'b0000, 4'b0000, 1'b1);
    stepCycle();
    stepCycle();
    rst = 1'b0;
    cyc = 0;
    stepTo(9);
    checkOutput("post_rst_t9", 1'b0, 4'b0000, 4'b0000, 1'b0);
    stepTo(10);
    checkOutput("post_rst_t10", 1'b1, 4'b0000, 4'b0000, 1'b1);
    stepTo(11);
    checkVal("post_rst_t11", 16'(tick_out), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
